// File: rtl/multiplexor_if.sv
// multiplexor_if: bundle of the data/select/enable inputs and the selected-lane
// outputs of the multiplexor.
// Parameters: N lanes of DATA_W bits each; SEL_W is the derived select width.
// Signals:
//   entradas  (N*DATA_W) packed lanes, lane k at [k*DATA_W +: DATA_W]
//   seleccion (SEL_W)    lane index
//   en                   capture enable for the registered path
//   salida    (DATA_W)   combinational selected lane
//   salida_q  (DATA_W)   registered selected lane
//   valid_q              salida_q holds a captured, in-range value
//   sel_err              seleccion >= N
//   chg_cnt   (16)       change counter, present only with MULTIPLEXOR_CHG_CNT_EN
// Modports: master drives the inputs, slave is the multiplexor side.
interface multiplexor_if #(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 1
);
    localparam int unsigned SEL_W = (N > 2) ? $clog2(N) : 1;

    logic [N*DATA_W-1:0] entradas;
    logic [SEL_W-1:0]    seleccion;
    logic                en;
    logic [DATA_W-1:0]   salida;
    logic [DATA_W-1:0]   salida_q;
    logic                valid_q;
    logic                sel_err;
`ifdef MULTIPLEXOR_CHG_CNT_EN
    logic [15:0]         chg_cnt;

    modport master (
        output entradas, seleccion, en,
        input  salida, salida_q, valid_q, sel_err, chg_cnt
    );
    modport slave (
        input  entradas, seleccion, en,
        output salida, salida_q, valid_q, sel_err, chg_cnt
    );
`else
    modport master (
        output entradas, seleccion, en,
        input  salida, salida_q, valid_q, sel_err
    );
    modport slave (
        input  entradas, seleccion, en,
        output salida, salida_q, valid_q, sel_err
    );
`endif
endinterface

// File: rtl/multiplexor.sv
// multiplexor: N-lane, DATA_W-bit selector with a combinational output and an
// enable-gated registered copy.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears salida_q, valid_q, chg_cnt)
//   bus_io multiplexor_if.slave carrying entradas/seleccion/en in and
//          salida/salida_q/valid_q/sel_err (and chg_cnt) out
// Optional feature: define MULTIPLEXOR_CHG_CNT_EN to add the saturating 16-bit
// chg_cnt output counting captures that changed salida_q.
module multiplexor #(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 1
) (
    input logic           clk,
    input logic           rst_n,
    multiplexor_if.slave  bus_io
);
    localparam int unsigned SEL_W = (N > 2) ? $clog2(N) : 1;

    logic [DATA_W-1:0] sel_data;
    logic              sel_err;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;

    // Out-of-range selects (non power-of-two N) fall through to all-zeros.
    always_comb begin
        sel_data = '0;
        sel_err  = (32'(bus_io.seleccion) >= N);
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(bus_io.seleccion) == k) begin
                sel_data = bus_io.entradas[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (bus_io.en) begin
            data_d  = sel_data;
            valid_d = ~sel_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus_io.salida   = sel_data;
    assign bus_io.sel_err  = sel_err;
    assign bus_io.salida_q = data_q;
    assign bus_io.valid_q  = valid_q;

`ifdef MULTIPLEXOR_CHG_CNT_EN
    logic [15:0] chg_d, chg_q;

    // Compares against the value being replaced, so a capture that reloads the
    // same value does not count; sticks at all-ones.
    always_comb begin
        chg_d = chg_q;
        if (bus_io.en && (sel_data != data_q) && (chg_q != 16'hFFFF)) begin
            chg_d = chg_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chg_q <= '0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign bus_io.chg_cnt = chg_q;
`endif
endmodule

// File: tb/tb_multiplexor.sv
// Scoreboard bench for multiplexor: a default instance (N=2, DATA_W=1) and a
// non power-of-two instance (N=3, DATA_W=4) share clock, reset and enable.
module tb_multiplexor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    always #5 clk = ~clk;

    multiplexor_if #(.N(2), .DATA_W(1)) bus2 ();
    multiplexor_if #(.N(3), .DATA_W(4)) bus3 ();

    multiplexor #(.N(2), .DATA_W(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus_io(bus2));
    multiplexor #(.N(3), .DATA_W(4)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus_io(bus3));

    assign bus2.en = en;
    assign bus3.en = en;

    typedef struct {
        logic [3:0]  c2;
        logic [3:0]  c3;
        logic        e3;
        logic [3:0]  r2;
        logic        v2;
        logic [3:0]  r3;
        logic        v3;
        logic [15:0] n2;
        logic [15:0] n3;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference state after the most recent edge
    logic [3:0]  m2 = '0, m3 = '0;
    logic        mv2 = 1'b0, mv3 = 1'b0;
    logic [15:0] cnt2 = '0, cnt3 = '0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push what the DUTs must show after the next edge.
    task automatic apply(input logic r, input logic e, input logic [1:0] a2,
                         input logic s2, input logic [11:0] a3, input logic [1:0] s3);
        exp_t x;
        logic [3:0] lane2;
        logic [3:0] lane3;
        @(negedge clk);
        rst_n = r;
        en = e;
        bus2.entradas = a2;
        bus2.seleccion = s2;
        bus3.entradas = a3;
        bus3.seleccion = s3;
        lane2 = 4'((a2 >> s2) & 2'b01);
        lane3 = (s3 >= 2'd3) ? 4'h0 : 4'((a3 >> (4 * s3)) & 12'hF);
        if (!r) begin
            m2 = '0; mv2 = 1'b0; cnt2 = '0;
            m3 = '0; mv3 = 1'b0; cnt3 = '0;
        end else if (e) begin
            if (lane2 != m2 && cnt2 != 16'hFFFF) cnt2 = cnt2 + 16'd1;
            if (lane3 != m3 && cnt3 != 16'hFFFF) cnt3 = cnt3 + 16'd1;
            m2 = lane2; mv2 = 1'b1;
            m3 = lane3; mv3 = (s3 < 2'd3);
        end
        x.c2 = lane2; x.c3 = lane3; x.e3 = (s3 >= 2'd3);
        x.r2 = m2; x.v2 = mv2; x.r3 = m3; x.v3 = mv3;
        x.n2 = cnt2; x.n3 = cnt3;
        sb.push_back(x);
    endtask

    // Monitor: inputs are stable from the previous negedge, so comb and
    // registered outputs are all valid just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("salida2", 16'(bus2.salida), 16'(x.c2[0]));
                chk("sel_err2", 16'(bus2.sel_err), 16'd0);
                chk("salida3", 16'(bus3.salida), 16'(x.c3));
                chk("sel_err3", 16'(bus3.sel_err), 16'(x.e3));
                chk("salida_q2", 16'(bus2.salida_q), 16'(x.r2[0]));
                chk("valid_q2", 16'(bus2.valid_q), 16'(x.v2));
                chk("salida_q3", 16'(bus3.salida_q), 16'(x.r3));
                chk("valid_q3", 16'(bus3.valid_q), 16'(x.v3));
`ifdef MULTIPLEXOR_CHG_CNT_EN
                chk("chg_cnt2", bus2.chg_cnt, x.n2);
                chk("chg_cnt3", bus3.chg_cnt, x.n3);
`endif
            end
        end
    end

    initial begin
        int wait_cycles;
        bus2.entradas = '0; bus2.seleccion = '0;
        bus3.entradas = '0; bus3.seleccion = '0;
        // Reset held for two edges, with en=1 so reset must win
        apply(1'b0, 1'b1, 2'b11, 1'b1, 12'hABC, 2'd1);
        apply(1'b0, 1'b1, 2'b11, 1'b1, 12'hABC, 2'd2);
        // Combinational lane selection while capture is disabled
        apply(1'b1, 1'b0, 2'b01, 1'b1, 12'h321, 2'd0);
        apply(1'b1, 1'b0, 2'b01, 1'b0, 12'h321, 2'd1);
        apply(1'b1, 1'b0, 2'b10, 1'b1, 12'h321, 2'd2);
        apply(1'b1, 1'b0, 2'b10, 1'b0, 12'h321, 2'd3);
        // Capture, then hold with en=0 while inputs move
        apply(1'b1, 1'b1, 2'b10, 1'b1, 12'h5A7, 2'd2);
        apply(1'b1, 1'b0, 2'b00, 1'b1, 12'h000, 2'd0);
        apply(1'b1, 1'b0, 2'b00, 1'b0, 12'hFFF, 2'd1);
        // Out-of-range select on the 3-lane instance clears valid_q
        apply(1'b1, 1'b1, 2'b10, 1'b1, 12'hFFF, 2'd3);
        // Reset with en=1 after live state
        apply(1'b0, 1'b1, 2'b10, 1'b1, 12'hFFF, 2'd0);
        // Selected value sequence 0,1,1,0,1 over five enabled edges
        apply(1'b1, 1'b1, 2'b10, 1'b0, 12'h000, 2'd0);
        apply(1'b1, 1'b1, 2'b10, 1'b1, 12'h010, 2'd1);
        apply(1'b1, 1'b1, 2'b10, 1'b1, 12'h010, 2'd1);
        apply(1'b1, 1'b1, 2'b10, 1'b0, 12'h010, 2'd0);
        apply(1'b1, 1'b1, 2'b10, 1'b1, 12'h010, 2'd1);
        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                  2'($urandom), 1'($urandom), 12'($urandom), 2'($urandom_range(0, 3)));
        end
        wait_cycles = 0;
        while (sb.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
